// File: rtl/run_controller.sv
`default_nettype none
// ============================================================================
// run_controller: start/clear/run/done sequencer with cycle-count watchdog
// Revision: 1.0
// ============================================================================
module run_controller #(
    parameter int MAX_CYCLES   = 4096,
    parameter int CNT_W        = 16,
    parameter int CLEAR_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    output logic             run_en,
    output logic             pc_clear,
    output logic             ack,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_CLEAR = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [3:0]       CLR_LAST = 4'(CLEAR_CYCLES - 1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] run_cnt;
    logic [3:0]       clr_cnt;
    logic             timeout_flag;
    logic             limit_hit;

    assign limit_hit = (run_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            run_cnt      <= '0;
            clr_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            state <= next_state;
            // Counters and the timeout flag are fresh on every entry to ARMED
            if ((next_state == S_ARMED) && (state != S_ARMED)) begin
                run_cnt      <= '0;
                clr_cnt      <= '0;
                timeout_flag <= 1'b0;
            end
            if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 4'd1;
            end
            if (state == S_RUN) begin
                run_cnt <= run_cnt + CNT_ONE;
                if (next_state == S_DONE) begin
                    timeout_flag <= !halt;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_ARMED;
            S_ARMED: if (!start) next_state = S_CLEAR;
            S_CLEAR: if (clr_cnt == CLR_LAST) next_state = S_RUN;
            // halt takes priority over the watchdog limit
            S_RUN:   if (halt || limit_hit) next_state = S_DONE;
            S_DONE:  if (start) next_state = S_ARMED;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        run_en      = (state == S_RUN);
        pc_clear    = (state == S_CLEAR);
        ack         = (state == S_DONE);
        timeout     = (state == S_DONE) && timeout_flag;
        cycle_count = run_cnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_run_controller.sv
`default_nettype none
// ============================================================================
// tb_run_controller: randomized run sequences checked against a run-level model
// Revision: 1.0
// ============================================================================
module tb_run_controller;

    localparam int MAXC = 4096;
    localparam int CLR0 = 1;
    localparam int CLR1 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_v    [2];
    logic        halt_v     [2];
    logic        run_en_v   [2];
    logic        pc_clear_v [2];
    logic        ack_v      [2];
    logic        timeout_v  [2];
    logic [15:0] count_v    [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_controller #(.MAX_CYCLES(MAXC), .CNT_W(16), .CLEAR_CYCLES(CLR0)) u_dut0 (
        .clk         (clk),
        .reset       (reset),
        .start       (start_v[0]),
        .halt        (halt_v[0]),
        .run_en      (run_en_v[0]),
        .pc_clear    (pc_clear_v[0]),
        .ack         (ack_v[0]),
        .timeout     (timeout_v[0]),
        .cycle_count (count_v[0])
    );

    run_controller #(.MAX_CYCLES(MAXC), .CNT_W(16), .CLEAR_CYCLES(CLR1)) u_dut1 (
        .clk         (clk),
        .reset       (reset),
        .start       (start_v[1]),
        .halt        (halt_v[1]),
        .run_en      (run_en_v[1]),
        .pc_clear    (pc_clear_v[1]),
        .ack         (ack_v[1]),
        .timeout     (timeout_v[1]),
        .cycle_count (count_v[1])
    );

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_run_en"}, run_en_v[d], 0);
        check({tag, "_pc_clear"}, pc_clear_v[d], 0);
        check({tag, "_ack"}, ack_v[d], 0);
        check({tag, "_timeout"}, timeout_v[d], 0);
        check({tag, "_count"}, count_v[d], 0);
    endtask

    // One complete program execution. halt_k = RUN cycle carrying halt (0 = never).
    // rst_at != 0 asserts reset during that RUN cycle instead of finishing.
    task automatic run_prog(input int d, input int hi_len, input int halt_k,
                            input bit noise, input int rst_at);
        int clr_len;
        int exp_run;
        bit exp_to;
        int pc_seen;
        int first_pc;
        int run_seen;
        int first_run;
        int last_run;
        int t;
        int frozen;
        bit done;
        bit aborted;

        clr_len   = (d == 0) ? CLR0 : CLR1;
        exp_to    = (halt_k == 0) || (halt_k > MAXC);
        exp_run   = exp_to ? MAXC : halt_k;
        pc_seen   = 0;
        first_pc  = -1;
        run_seen  = 0;
        first_run = -1;
        last_run  = -1;
        t         = 0;
        done      = 1'b0;
        aborted   = 1'b0;

        start_v[d] = 1'b1;
        halt_v[d]  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int i = 0; i < hi_len; i++) begin
            step();
            check("armed_ack", ack_v[d], 0);
            check("armed_count", count_v[d], 0);
            check("armed_timeout", timeout_v[d], 0);
            check("armed_pc_clear", pc_clear_v[d], 0);
            check("armed_run_en", run_en_v[d], 0);
            if (noise) halt_v[d] = 1'($urandom_range(0, 1));
        end
        start_v[d] = 1'b0;

        while (!done && (t < MAXC + clr_len + 8)) begin
            step();
            t++;
            check("overlap", pc_clear_v[d] & run_en_v[d], 0);
            start_v[d] = 1'b0;
            halt_v[d]  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (pc_clear_v[d]) begin
                pc_seen++;
                if (first_pc < 0) first_pc = t;
                check("pc_after_run", run_seen, 0);
                if (noise) start_v[d] = 1'($urandom_range(0, 1));
            end
            if (run_en_v[d]) begin
                run_seen++;
                last_run = t;
                if (first_run < 0) first_run = t;
                check("run_count", count_v[d], run_seen - 1);
                if (noise) start_v[d] = 1'($urandom_range(0, 1));
                halt_v[d] = (run_seen == halt_k);
                if ((rst_at != 0) && (run_seen == rst_at)) begin
                    reset = 1'b1;
                    step();
                    reset = 1'b0;
                    start_v[d] = 1'b0;
                    halt_v[d]  = 1'b0;
                    check_quiet(d, "reset_abort");
                    step();
                    check_quiet(d, "reset_idle");
                    aborted = 1'b1;
                    done = 1'b1;
                end
            end
            if (!aborted && ack_v[d]) begin
                done = 1'b1;
                check("pc_clear_len", pc_seen, clr_len);
                check("pc_first", first_pc, 1);
                check("run_first", first_run, clr_len + 1);
                check("run_len", run_seen, exp_run);
                check("ack_latency", t, last_run + 1);
                check("done_timeout", timeout_v[d], exp_to);
                check("done_count", count_v[d], exp_run);
            end
        end
        check("cycle_budget", done, 1);

        if (done && !aborted) begin
            for (int i = 0; i < 3; i++) begin
                start_v[d] = 1'b0;
                halt_v[d]  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                frozen = count_v[d];
                check("hold_ack", ack_v[d], 1);
                check("hold_run_en", run_en_v[d], 0);
                check("hold_count", frozen, exp_run);
                check("hold_timeout", timeout_v[d], exp_to);
            end
        end
        halt_v[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            halt_v[d]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) step();
        check_quiet(0, "reset0");
        check_quiet(1, "reset1");
        reset = 1'b0;

        // halt in IDLE is ignored
        halt_v[0] = 1'b1;
        halt_v[1] = 1'b1;
        repeat (3) step();
        check_quiet(0, "idle_halt0");
        check_quiet(1, "idle_halt1");
        halt_v[0] = 1'b0;
        halt_v[1] = 1'b0;

        run_prog(0, 3, 5, 1'b0, 0);
        run_prog(0, 3, 0, 1'b0, 0);
        run_prog(0, 2, MAXC, 1'b0, 0);
        run_prog(0, 3, 0, 1'b1, 0);
        run_prog(0, 3, 0, 1'b0, 10);
        run_prog(0, 3, 7, 1'b0, 0);
        run_prog(1, 3, 4, 1'b0, 0);
        run_prog(1, 1, 2, 1'b0, 0);
        run_prog(1, 30, 3, 1'b1, 0);

        repeat (12) begin
            run_prog(int'($urandom_range(0, 1)), int'($urandom_range(1, 5)),
                     int'($urandom_range(1, 80)), 1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/run_controller.md
Name: run_controller

Overview:
- Sequences the 9-bit-instruction processor core through one program execution: arms on `start`, clears the PC, enables execution, detects the halt instruction, and returns `ack`.
- Also runs the cycle-count watchdog. If the program never halts, the block forces `ack` and flags `timeout`.
- Sits in the top level between the testbench handshake and the datapath. It replaces the ad-hoc `ever_start`/`start_off`/overflow logic.
- The top level forces NOP into the control decoder whenever `run_en`=0.

Parameters:
- MAX_CYCLES, 4096, number of RUN cycles after which execution is aborted with `timeout`.
- CNT_W, 16, width of `cycle_count`. Must satisfy 2^CNT_W > MAX_CYCLES.
- CLEAR_CYCLES, 1, number of cycles `pc_clear` is held before RUN. Legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  testbench request. A program runs after a 1→0 transition of `start`.
- halt  input  1  `done` decode of the current instruction. Sampled only in RUN.
- run_en  output  1  high only in RUN. The processor executes only when this is high; otherwise it sees NOP.
- pc_clear  output  1  high in CLEAR. Forces PC to 0 (the PC register is loaded with 0 on that edge).
- ack  output  1  high in DONE. Program finished or aborted.
- timeout  output  1  high in DONE when the finish was caused by the watchdog.
- cycle_count  output  CNT_W  number of RUN cycles in the current or last run.

Behaviour:
- Reset: state=IDLE, run_en=0, pc_clear=0, ack=0, timeout=0, cycle_count=0. Reset mid-run aborts immediately with the same values on the next cycle; no ack is produced.
- All outputs are decoded from registered state and registered counters. There is no combinational path from any input to any output.
- States: IDLE, ARMED, CLEAR, RUN, DONE.
- IDLE:
  - start=1 → ARMED; otherwise stay.
- ARMED:
  - Entry clears cycle_count to 0, timeout to 0, and the clear counter to 0.
  - Stay while start=1. Sampled start=0 → CLEAR.
- CLEAR:
  - pc_clear=1 and run_en=0.
  - Stays exactly CLEAR_CYCLES cycles, then → RUN.
  - `start` is ignored.
- RUN:
  - run_en=1.
  - Every RUN cycle increments cycle_count by 1, including the cycle in which halt is seen.
  - halt=1 → DONE with timeout=0.
  - Else, if the pre-increment cycle_count == MAX_CYCLES-1 → DONE with timeout=1. cycle_count then reads MAX_CYCLES.
  - halt and the watchdog limit in the same cycle: halt wins, timeout=0.
  - `start` is ignored in RUN.
- DONE:
  - ack=1, run_en=0, and cycle_count and timeout are frozen.
  - start=1 → ARMED, which drops ack and clears the count and timeout on that transition.
  - Otherwise stay indefinitely.
- halt is ignored in every state except RUN.
- Timing: start sampled 0 in ARMED at edge N. pc_clear is high in cycles N+1..N+CLEAR_CYCLES. run_en first goes high in cycle N+CLEAR_CYCLES+1. If halt arrives in RUN cycle k (1-based), ack rises one cycle later and cycle_count=k.
- cycle_count never wraps. The watchdog terminates the run at exactly MAX_CYCLES.
- start held high forever never starts a run; the block stays in ARMED.
- The testbench may reuse the block: DONE → ARMED → CLEAR → RUN repeats with a fresh count each time.

Test Plan:
- Reset, then start pulse 3 cycles high, then low; halt=1 on the 5th RUN cycle → pc_clear high exactly 1 cycle, run_en high 5 cycles, ack=1 on the next cycle, cycle_count=5, timeout=0.
- Same stimulus with halt never asserted, MAX_CYCLES=4096 → run_en high 4096 cycles, then ack=1, timeout=1, cycle_count=4096.
- halt=1 in the same cycle the watchdog limit is hit (halt on RUN cycle 4096) → ack=1, timeout=0, cycle_count=4096.
- halt, and start toggled 1/0, during IDLE, ARMED, CLEAR and mid-RUN (halt stays low throughout) → no state change except IDLE→ARMED and ARMED→CLEAR; the run completes by watchdog with no restart.
- reset asserted on RUN cycle 10 → next cycle all outputs 0 and state IDLE; a following start pulse runs normally, with cycle_count starting from 0.
- Back-to-back runs: after ack, start 1 cycle high then low with CLEAR_CYCLES=3, halt on RUN cycle 2 → ack drops the cycle after start is sampled, pc_clear high 3 cycles, final cycle_count=2.
